// File: rtl/uart_rx_fifo.sv
// Receive byte buffer between the UART receiver and the command decoder.
// Captures and acknowledges rx bytes, then replays them as spaced strobes.
module uart_rx_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int STB_GAP    = 1
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [7:0]            i_rx_word,
  input  logic                  i_rx_rxne,
  input  logic                  i_rx_ore,
  output logic                  o_rxne_clear,
  output logic [7:0]            o_data,
  output logic                  o_stb,
  input  logic                  i_hold,
  output logic [DEPTH_LOG2:0]   o_level,
  output logic                  o_empty,
  output logic                  o_full,
  output logic [7:0]            o_drop_cnt,
  input  logic                  i_drop_clr
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int GW    = (STB_GAP > 0) ? $clog2(STB_GAP + 1) : 1;
  localparam logic [DEPTH_LOG2:0] FULL_LVL = (DEPTH_LOG2+1)'(DEPTH);

  typedef enum logic {S_IDLE, S_WAIT_LOW} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [7:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_level;
  logic [GW-1:0]         r_gap;
  logic [7:0]            r_data;
  logic                  r_stb;
  logic                  r_rxne_clear;
  logic [7:0]            r_drop;
  logic                  r_ore_d;
  logic                  w_cap;
  logic                  w_wr;
  logic                  w_drop_full;
  logic                  w_pop;
  logic                  w_ore_rise;
  logic [1:0]            w_inc;
  logic [8:0]            w_sum;

  assign o_empty      = (r_level == '0);
  assign o_full       = (r_level == FULL_LVL);
  assign o_level      = r_level;
  assign o_data       = r_data;
  assign o_stb        = r_stb;
  assign o_rxne_clear = r_rxne_clear;
  assign o_drop_cnt   = r_drop;

  always_comb begin
    w_state_nxt = r_state;
    w_cap       = 1'b0;
    w_wr        = 1'b0;
    w_drop_full = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (i_rx_rxne) begin
          w_cap       = 1'b1;
          w_wr        = !o_full;
          w_drop_full = o_full;
          w_state_nxt = S_WAIT_LOW;
        end
      end
      S_WAIT_LOW: begin
        if (!i_rx_rxne) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Full is judged on the start-of-cycle level; a same-cycle pop never rescues
  assign w_pop      = !o_empty && !i_hold && (r_gap == '0);
  assign w_ore_rise = i_rx_ore && !r_ore_d;
  assign w_inc      = {1'b0, w_drop_full} + {1'b0, w_ore_rise};
  assign w_sum      = {1'b0, r_drop} + 9'(w_inc);

  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_rx_word;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_level      <= '0;
      r_gap        <= '0;
      r_data       <= '0;
      r_stb        <= 1'b0;
      r_rxne_clear <= 1'b0;
      r_drop       <= '0;
      r_ore_d      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_rxne_clear <= w_cap;
      r_ore_d      <= i_rx_ore;
      r_stb        <= w_pop;
      if (w_wr) r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
      if (w_pop) begin
        r_data   <= r_mem[r_rd_ptr];
        r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
        r_gap    <= GW'(STB_GAP);
      end else if (r_gap != '0) begin
        r_gap <= r_gap - GW'(1);
      end
      unique case ({w_wr, w_pop})
        2'b10:   r_level <= r_level + (DEPTH_LOG2+1)'(1);
        2'b01:   r_level <= r_level - (DEPTH_LOG2+1)'(1);
        default: r_level <= r_level;
      endcase
      if (i_drop_clr)   r_drop <= '0;
      else if (w_sum[8]) r_drop <= 8'hFF;
      else              r_drop <= w_sum[7:0];
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (DEPTH_LOG2=4, STB_GAP=1).
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_word;
  logic       rxne;
  logic       ore;
  logic       rxne_clear;
  logic [7:0] data;
  logic       stb;
  logic       hold;
  logic [4:0] level;
  logic       empty;
  logic       full;
  logic [7:0] drop_cnt;
  logic       drop_clr;

  int n_tests = 0;
  int n_fail  = 0;
  int max_lvl = 0;
  int cnt;

  always #5 clk = ~clk;

  uart_rx_fifo #(.DEPTH_LOG2(4), .STB_GAP(1)) dut (
    .i_clk(clk), .i_reset(rst), .i_rx_word(rx_word), .i_rx_rxne(rxne),
    .i_rx_ore(ore), .o_rxne_clear(rxne_clear), .o_data(data), .o_stb(stb),
    .i_hold(hold), .o_level(level), .o_empty(empty), .o_full(full),
    .o_drop_cnt(drop_cnt), .i_drop_clr(drop_clr)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (int'(level) > max_lvl) max_lvl = int'(level);
  endtask

  // One byte: rxne high in cycle N, acknowledged in N+1, released there.
  task automatic send(input logic [7:0] b, input bit chk_stb);
    rx_word = b;
    rxne    = 1'b1;
    tick();
    chk("rxne_clear_n1", int'(rxne_clear), 1);
    rxne = 1'b0;
    tick();
    chk("rxne_clear_n2", int'(rxne_clear), 0);
    if (chk_stb) begin
      chk("stb_n2", int'(stb), 1);
      chk("data_n2", int'(data), int'(b));
    end
  endtask

  initial begin
    rst = 1'b1; rx_word = '0; rxne = 0; ore = 0; hold = 0; drop_clr = 0;
    tick(); tick();
    chk("rst_level", int'(level), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_stb", int'(stb), 0);
    chk("rst_drop", int'(drop_cnt), 0);
    rst = 1'b0;
    tick();

    // single byte, 2-cycle latency
    rx_word = 8'hA5; rxne = 1'b1;
    tick();
    chk("single_clear", int'(rxne_clear), 1);
    chk("single_level1", int'(level), 1);
    chk("single_empty0", int'(empty), 0);
    chk("single_nostb", int'(stb), 0);
    rxne = 1'b0;
    tick();
    chk("single_stb", int'(stb), 1);
    chk("single_data", int'(data), 8'hA5);
    chk("single_level0", int'(level), 0);
    chk("single_drop", int'(drop_cnt), 0);
    tick();
    chk("single_stb_once", int'(stb), 0);

    // burst under hold, overflow drop, ordered release at gap 2
    hold = 1'b1;
    for (int i = 0; i < 16; i++) send(8'(i), 1'b0);
    chk("burst_full", int'(full), 1);
    chk("burst_level", int'(level), 16);
    send(8'hFF, 1'b0);
    chk("burst_drop", int'(drop_cnt), 1);
    chk("burst_level_kept", int'(level), 16);
    chk("burst_hold_nostb", int'(stb), 0);
    hold = 1'b0;
    for (int k = 0; k < 32; k++) begin
      tick();
      chk("release_stb", int'(stb), (k % 2 == 0) ? 1 : 0);
      if (k % 2 == 0) chk("release_data", int'(data), k / 2);
    end
    chk("release_empty", int'(empty), 1);
    chk("release_level", int'(level), 0);

    // wrap-around at line rate
    max_lvl = 0;
    for (int i = 0; i < 40; i++) send(8'(8'h40 + i), 1'b1);
    chk("wrap_maxlvl_le2", int'(max_lvl <= 2), 1);
    chk("wrap_drop", int'(drop_cnt), 1);

    // write and pop in one cycle at level 5
    tick(); tick();
    hold = 1'b1;
    for (int i = 0; i < 5; i++) send(8'(8'h60 + i), 1'b0);
    chk("wp_level5", int'(level), 5);
    hold = 1'b0; rx_word = 8'h65; rxne = 1'b1;
    tick();
    chk("wp_level_same", int'(level), 5);
    chk("wp_stb", int'(stb), 1);
    chk("wp_data", int'(data), 8'h60);
    rxne = 1'b0;
    cnt = 0;
    for (int k = 0; k < 14; k++) begin
      tick();
      if (stb) begin
        cnt++;
        chk("wp_order", int'(data), 8'h60 + cnt);
      end
    end
    chk("wp_count", cnt, 5);
    chk("wp_empty", int'(empty), 1);

    // overrun edge plus full drop in the same cycle
    hold = 1'b1;
    for (int i = 0; i < 16; i++) send(8'(8'h80 + i), 1'b0);
    ore = 1'b1; rxne = 1'b1; rx_word = 8'hEE;
    tick();
    chk("dual_drop", int'(drop_cnt), 3);
    chk("dual_level", int'(level), 16);
    rxne = 1'b0;
    tick();
    ore = 1'b0;
    tick();
    ore = 1'b1; drop_clr = 1'b1;
    tick();
    chk("clr_wins", int'(drop_cnt), 0);
    drop_clr = 1'b0; ore = 1'b0;
    tick();

    // saturation
    for (int i = 0; i < 300; i++) begin
      ore = 1'b1; tick();
      ore = 1'b0; tick();
    end
    chk("saturate", int'(drop_cnt), 255);

    hold = 1'b0;
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (stb) begin
        chk("drain_order", int'(data), 8'h80 + cnt);
        cnt++;
      end
    end
    chk("drain_count", cnt, 16);
    chk("drain_empty", int'(empty), 1);
    drop_clr = 1'b1;
    tick();
    drop_clr = 1'b0;
    chk("clr_only", int'(drop_cnt), 0);

    // rxne held for 10 cycles
    hold = 1'b1; rx_word = 8'h77; rxne = 1'b1;
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (rxne_clear) cnt++;
    end
    rxne = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      if (rxne_clear) cnt++;
    end
    chk("hold_rxne_clears", cnt, 1);
    chk("hold_rxne_level", int'(level), 1);

    // reset mid-stream with 7 bytes and a strobe in flight
    for (int i = 0; i < 6; i++) send(8'(8'h90 + i), 1'b0);
    chk("mid_level7", int'(level), 7);
    hold = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_stb_live", int'(stb), 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_stb", int'(stb), 0);
    chk("mid_rst_data", int'(data), 0);
    chk("mid_rst_level", int'(level), 0);
    chk("mid_rst_empty", int'(empty), 1);
    chk("mid_rst_full", int'(full), 0);
    chk("mid_rst_clear", int'(rxne_clear), 0);
    tick(); tick();
    rst = 1'b0;
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (stb) cnt++;
    end
    chk("post_rst_nostb", cnt, 0);
    send(8'h3C, 1'b1);
    chk("post_rst_level", int'(level), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte buffer between the UART receiver and the command decoder. It captures each received byte and acknowledges the receiver's data-ready flag, so back-to-back bytes are not lost while the Wishbone master is busy. It replays bytes to the decoder as single-cycle strobes with guaranteed spacing, and counts every byte lost to FIFO overflow or receiver overrun.

## Interface

Parameters:
- DEPTH_LOG2, 4: FIFO depth is 2**DEPTH_LOG2 bytes (16).
- STB_GAP, 1: minimum number of idle cycles between consecutive o_stb pulses (0 allows back-to-back).

Ports (one clock; reset is asynchronous and active-high):
- i_clk  in  1  system clock (12 MHz board clock).
- i_reset  in  1  asynchronous, active-high reset.
- i_rx_word  in  8  received byte from the UART receiver, valid while i_rx_rxne=1.
- i_rx_rxne  in  1  receiver data-ready flag (level, held until cleared).
- i_rx_ore  in  1  receiver overrun flag (level).
- o_rxne_clear  out  1  one-cycle pulse that clears the receiver's data-ready flag.
- o_data  out  8  byte presented to the decoder; valid in the o_stb cycle, held afterwards.
- o_stb  out  1  one-cycle strobe, one per byte.
- i_hold  in  1  downstream backpressure (tie to the master's command-busy); 1 = do not pop.
- o_level  out  DEPTH_LOG2+1  current occupancy, 0..2**DEPTH_LOG2.
- o_empty  out  1  o_level==0.
- o_full  out  1  o_level==2**DEPTH_LOG2.
- o_drop_cnt  out  8  saturating count of lost bytes.
- i_drop_clr  in  1  synchronous clear of o_drop_cnt.

## Operation

- Storage: circular buffer with write/read pointers of DEPTH_LOG2 bits that wrap modulo the depth, plus a level counter. o_empty and o_full are derived from the level counter, not from pointer equality.
- Capture FSM, states IDLE and WAIT_LOW:
  - IDLE with i_rx_rxne=1:
    - If not full, write i_rx_word.
    - If full, discard the byte and increment the drop count.
    - Either way, pulse o_rxne_clear next cycle and go to WAIT_LOW.
  - WAIT_LOW: stay until i_rx_rxne=0, then return to IDLE. This prevents a double capture while the receiver is still clearing.
- Full test uses the level at the start of the cycle. A pop in the same cycle does not rescue a write into a full FIFO; the byte is dropped.
- Overrun: each rising edge of i_rx_ore (registered previous value) increments the drop count.
- Drop counter:
  - Saturates at 255.
  - Two increment sources in the same cycle add 2 (still saturating).
  - i_drop_clr=1 zeroes the counter and wins over any increments in that cycle.
- Pop path: a pop happens in a cycle where o_empty=0, i_hold=0 and the gap counter is 0.
  - The pop registers o_data from the read pointer, pulses o_stb next cycle, advances the read pointer, and loads the gap counter with STB_GAP.
  - The gap counter decrements to 0 in each non-pop cycle.
- Simultaneous write and pop: both take effect and the level is unchanged.
- i_hold is sampled only in the pop-decision cycle. A strobe already registered still issues.

## Timing

- Reset values, all asynchronous on i_reset:
  - Pointers, level, o_data, o_stb, o_rxne_clear, o_drop_cnt and the gap counter are 0.
  - o_empty=1, o_full=0, FSM in IDLE.
- Reset mid-operation discards all FIFO contents and any pending strobe.
- Capture: i_rx_rxne sampled high in IDLE at cycle N means the byte is written at the end of N, o_rxne_clear=1 in cycle N+1 only, and o_level increments in N+1.
- Latency: o_empty drops in N+1. The pop decision is taken in N+1, so o_stb=1 with o_data valid in N+2. Minimum rx-to-strobe latency is 2 cycles.
- Strobe spacing: with STB_GAP=g and a continuously non-empty FIFO, o_stb is high every g+1 cycles.
- Release: o_stb never rises during a cycle in which i_hold was high at the decision edge. After i_hold falls at cycle M, the first o_stb is at M+1 at the earliest.
- Level updates in the cycle after the write/pop edge and stays consistent with o_empty and o_full.

## Test plan

- Single byte: reset, then drive i_rx_word=0xA5 and i_rx_rxne=1 until o_rxne_clear. Expect o_rxne_clear in cycle N+1, o_stb with o_data=0xA5 in N+2, o_level back to 0, o_drop_cnt=0.
- Burst with hold: i_hold=1, push 16 bytes 0x00..0x0F, then a 17th byte 0xFF. Expect o_full=1, 0xFF acknowledged but dropped, o_drop_cnt=1. Release hold: expect 16 strobes 0x00..0x0F in order, spaced 2 cycles apart (STB_GAP=1), then o_empty=1.
- Wrap-around: 40 bytes pushed while popping at line rate. Expect order preserved across pointer wrap, o_level never above 2, no drops.
- Simultaneous events:
  - Write and pop in the same cycle at level 5: expect level stays 5.
  - i_rx_ore rising edge together with a full-FIFO drop: expect o_drop_cnt +2.
  - i_drop_clr asserted in the same cycle as an increment: expect 0.
- Saturation and RXNE hold: 300 overrun edges give o_drop_cnt=255. i_rx_rxne held high for 10 cycles gives exactly one capture and one o_rxne_clear pulse.
- Reset mid-stream: assert i_reset with 7 bytes buffered and an o_stb pending. Expect all outputs at reset values immediately, and no o_stb after release until a new byte arrives.
